// File: rtl/roce_tx_write_segmenter.sv
// RDMA WRITE transmit segmenter: splits one transfer into PMTU-sized RC packets.
// Define ROCE_WRITE_IMM_EN to emit the WITH_IMM opcodes on the last packet when write_type is set.
module roce_tx_write_segmenter #(
  parameter int unsigned PMTU_LOG2 = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_transfer_i,
  input  logic        metadata_valid_i,
  input  logic [31:0] dma_transfer_i,
  input  logic [63:0] rem_addr_i,
  input  logic [31:0] r_key_i,
  input  logic [23:0] rem_qpn_i,
  input  logic [23:0] loc_psn_i,
  input  logic        write_type_i,
  output logic        m_seg_valid_o,
  input  logic        m_seg_ready_i,
  output logic [7:0]  m_seg_opcode_o,
  output logic [23:0] m_seg_psn_o,
  output logic [63:0] m_seg_vaddr_o,
  output logic [15:0] m_seg_length_o,
  output logic [31:0] m_seg_dma_length_o,
  output logic [31:0] m_seg_r_key_o,
  output logic [23:0] m_seg_dest_qpn_o,
  output logic [23:0] next_psn_o,
  output logic        done_o,
  output logic        busy_o
);

  localparam logic [31:0] PmtuBytes = 32'd1 << PMTU_LOG2;

  localparam logic [7:0] OpFirst   = 8'h06;
  localparam logic [7:0] OpMiddle  = 8'h07;
  localparam logic [7:0] OpLast    = 8'h08;
  localparam logic [7:0] OpLastImm = 8'h09;
  localparam logic [7:0] OpOnly    = 8'h0A;
  localparam logic [7:0] OpOnlyImm = 8'h0B;

  typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

  state_e      state_q;
  logic        start_q;
  logic [31:0] remaining_q;
  logic        last_q;
  logic        imm_q;
  logic        valid_q;
  logic [7:0]  opcode_q;
  logic [23:0] psn_q;
  logic [63:0] vaddr_q;
  logic [15:0] length_q;
  logic [31:0] dma_len_q;
  logic [31:0] r_key_q;
  logic [23:0] qpn_q;
  logic [23:0] next_psn_q;
  logic        done_q;
  logic        busy_q;

  logic        start_evt;
  logic        handshake;
  logic        imm_capture;
  logic        first_is_last;
  logic [31:0] rem_after;
  logic        next_is_last;

`ifdef ROCE_WRITE_IMM_EN
  assign imm_capture = write_type_i;
`else
  logic unused_write_type;
  assign unused_write_type = write_type_i;
  assign imm_capture       = 1'b0;
`endif

  function automatic logic [15:0] seg_len(input logic [31:0] rem);
    if (rem <= PmtuBytes) return rem[15:0];
    return PmtuBytes[15:0];
  endfunction

  function automatic logic [7:0] opcode_sel(input logic first, input logic last, input logic imm);
    logic [7:0] op;
    op = OpMiddle;
    unique case ({first, last})
      2'b11:   op = imm ? OpOnlyImm : OpOnly;
      2'b10:   op = OpFirst;
      2'b01:   op = imm ? OpLastImm : OpLast;
      default: op = OpMiddle;
    endcase
    return op;
  endfunction

  // Edge detect uses the previous start_transfer level, independent of metadata_valid.
  assign start_evt     = start_transfer_i & metadata_valid_i & ~start_q;
  assign handshake     = valid_q & m_seg_ready_i;
  assign first_is_last = dma_transfer_i <= PmtuBytes;
  assign rem_after     = remaining_q - {16'd0, length_q};
  assign next_is_last  = rem_after <= PmtuBytes;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      start_q     <= 1'b0;
      remaining_q <= '0;
      last_q      <= 1'b0;
      imm_q       <= 1'b0;
      valid_q     <= 1'b0;
      opcode_q    <= '0;
      psn_q       <= '0;
      vaddr_q     <= '0;
      length_q    <= '0;
      dma_len_q   <= '0;
      r_key_q     <= '0;
      qpn_q       <= '0;
      next_psn_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      start_q <= start_transfer_i;
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_evt) begin
            state_q     <= StIssue;
            remaining_q <= dma_transfer_i;
            last_q      <= first_is_last;
            imm_q       <= imm_capture;
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
            opcode_q    <= opcode_sel(1'b1, first_is_last, imm_capture);
            psn_q       <= loc_psn_i;
            vaddr_q     <= rem_addr_i;
            length_q    <= seg_len(dma_transfer_i);
            dma_len_q   <= dma_transfer_i;
            r_key_q     <= r_key_i;
            qpn_q       <= rem_qpn_i;
          end
        end
        StIssue: begin
          if (handshake) begin
            if (last_q) begin
              state_q    <= StDone;
              valid_q    <= 1'b0;
              done_q     <= 1'b0 | 1'b1;
              next_psn_q <= psn_q + 24'd1;
            end else begin
              // Present the following segment; it can never be a first segment.
              remaining_q <= rem_after;
              last_q      <= next_is_last;
              opcode_q    <= opcode_sel(1'b0, next_is_last, imm_q);
              psn_q       <= psn_q + 24'd1;
              vaddr_q     <= vaddr_q + {48'd0, length_q};
              length_q    <= seg_len(rem_after);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_seg_valid_o      = valid_q;
  assign m_seg_opcode_o     = opcode_q;
  assign m_seg_psn_o        = psn_q;
  assign m_seg_vaddr_o      = vaddr_q;
  assign m_seg_length_o     = length_q;
  assign m_seg_dma_length_o = dma_len_q;
  assign m_seg_r_key_o      = r_key_q;
  assign m_seg_dest_qpn_o   = qpn_q;
  assign next_psn_o         = next_psn_q;
  assign done_o             = done_q;
  assign busy_o             = busy_q;

endmodule
